expand_tokens: RTL and testbench

//   Serial token expander, the inverse of the token-halving stage: every '1' token accepted on a

---
 rtl/expand_tokens_pkg.sv | 13 +
 rtl/expand_tokens_if.sv | 21 ++
 rtl/expand_tokens.sv | 70 +++++++
 tb/tb_expand_tokens.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/expand_tokens_pkg.sv
// Shared constants and helpers for the serial token expander.
// The optional drop flag is enabled with EXPAND_TOKENS_DROP_FLAG_EN.
package expand_tokens_pkg;

  localparam int EXPAND_TOKENS_DEF_FACTOR = 2;
  localparam int EXPAND_TOKENS_DEF_CAP    = 4;

  // Width that holds every credit value from 0 up to and including cap.
  function automatic int credit_width(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/expand_tokens_if.sv
// Token handshake bundle: producer side (a/a_ready) and consumer side (b/b_ready).
// With EXPAND_TOKENS_DROP_FLAG_EN defined the bundle also carries the sticky drop flag.
interface expand_tokens_if;

  logic a;
  logic a_ready;
  logic b;
  logic b_ready;
`ifdef EXPAND_TOKENS_DROP_FLAG_EN
  logic drop;
`endif

`ifdef EXPAND_TOKENS_DROP_FLAG_EN
  modport master (output a, output b_ready, input a_ready, input b, input drop);
  modport slave  (input a, input b_ready, output a_ready, output b, output drop);
`else
  modport master (output a, output b_ready, input a_ready, input b);
  modport slave  (input a, input b_ready, output a_ready, output b);
`endif

endinterface

// File: rtl/expand_tokens.sv
// Serial token expander: each accepted input token becomes FACTOR output tokens, held as credit.
// Define EXPAND_TOKENS_DROP_FLAG_EN to add the sticky drop flag for tokens offered while not ready.
module expand_tokens
  import expand_tokens_pkg::*;
#(
  parameter int FACTOR = EXPAND_TOKENS_DEF_FACTOR,
  parameter int CAP    = EXPAND_TOKENS_DEF_CAP
) (
  input  logic           clk,
  input  logic           rst,
  expand_tokens_if.slave bus
);

  localparam int CREDIT_W = credit_width(CAP);
  typedef logic [CREDIT_W-1:0] credit_t;

  localparam credit_t FILL_LIMIT = credit_t'(CAP - FACTOR);
  localparam credit_t CAP_C      = credit_t'(CAP);
  localparam credit_t STEP       = credit_t'(FACTOR);

  credit_t credit;
  credit_t credit_nxt;
  logic    can_take;
  logic    acc;
  logic    emit;

  // Room for a whole token's worth of credit; both outputs are forced low while in reset.
  assign can_take    = (credit <= FILL_LIMIT);
  assign bus.a_ready = !rst && can_take;
  assign emit        = !rst && (credit != '0) && bus.b_ready;
  assign bus.b       = emit;
  assign acc         = bus.a && bus.a_ready;

  always_comb begin
    // NOTE: default assigned first so every path drives credit_nxt and no latch is inferred.
    credit_nxt = credit;
    if (acc) begin
      credit_nxt = credit_nxt + STEP;
    end
    if (emit) begin
      credit_nxt = credit_nxt - credit_t'(1);
    end
  end

`ifdef EXPAND_TOKENS_DROP_FLAG_EN
  logic drop;
  assign bus.drop = drop;
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update tied to the same clock edge.
    if (rst) begin
      credit <= '0;
`ifdef EXPAND_TOKENS_DROP_FLAG_EN
      drop   <= 1'b0;
`endif
    end else begin
      credit <= credit_nxt;
`ifdef EXPAND_TOKENS_DROP_FLAG_EN
      if (bus.a && !can_take) begin
        drop <= 1'b1;
      end
`endif
    end
  end

  // Acceptance is gated on headroom, so the credit must never pass CAP.
  credit_bound_a : assert property (@(posedge clk) disable iff (rst) credit <= CAP_C);

endmodule

// File: tb/tb_expand_tokens.sv
// Self-checking bench for expand_tokens: directed vector table, a FACTOR=3/CAP=3 corner sequence,
// and steady/random traffic against a count-based reference model.
module tb_expand_tokens;

  localparam int F = 2;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  expand_tokens_if bus ();
  expand_tokens_if bus3 ();

  expand_tokens #(.FACTOR(F), .CAP(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  expand_tokens #(.FACTOR(3), .CAP(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic a, input logic br);
    @(negedge clk);
    rst        = r;
    bus.a      = a;
    bus.b_ready = br;
    #1;
  endtask

  task automatic drive3(input logic r, input logic a, input logic br);
    @(negedge clk);
    rst          = r;
    bus3.a       = a;
    bus3.b_ready = br;
    #1;
  endtask

  // Expected values of -1 are not compared (e.g. registers still unknown before first reset edge).
  typedef struct {
    logic rst;
    logic a;
    logic br;
    int   b;
    int   ar;
    int   drop;
    int   credit;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic a, input logic br,
                     input int b, input int ar, input int drop, input int credit);
    vec_t v;
    v.rst = r; v.a = a; v.br = br; v.b = b; v.ar = ar; v.drop = drop; v.credit = credit;
    tbl.push_back(v);
  endtask

  int m_acc, m_emit, o_acc, o_emit;

  task automatic model_cycle(input logic a, input logic br);
    int pend;
    int exp_ar;
    int exp_b;
    drive(1'b0, a, br);
    pend   = F * m_acc - m_emit;
    exp_ar = (pend <= C - F) ? 1 : 0;
    exp_b  = (pend > 0 && br) ? 1 : 0;
    check("model_b", int'(bus.b), exp_b);
    check("model_a_ready", int'(bus.a_ready), exp_ar);
    check("model_credit", int'(dut.credit), pend);
    check("conservation", int'(dut.credit), F * o_acc - o_emit);
    check("credit_le_cap", int'(int'(dut.credit) <= C), 1);
    if (a && exp_ar == 1) m_acc++;
    if (exp_b == 1) m_emit++;
    if (a && bus.a_ready) o_acc++;
    if (bus.b) o_emit++;
  endtask

  initial begin
    rst          = 1'b1;
    bus.a        = 1'b0;
    bus.b_ready  = 1'b0;
    bus3.a       = 1'b0;
    bus3.b_ready = 1'b0;

    // Reset and idle
    add(1, 0, 0, -1, -1, -1, -1);
    add(1, 0, 1,  0,  0,  0,  0);
    add(0, 0, 1,  0,  1,  0,  0);
    add(0, 0, 0,  0,  1,  0,  0);
    // b_ready=1: a 1,0,0,0,1,1,0,0,0,0 -> b 0,1,1,0,0,1,1,1,1,0
    add(0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 1, 1, 1, 0, 2);
    add(0, 0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 0, 2);
    add(0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 1, 1, 1, 0, 2);
    add(0, 0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0);
    // Stalled consumer fills to full, drop raised, then drained by exactly 4 pulses
    add(0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 1, 0, 2);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 1, 4);
    add(0, 0, 1, 1, 0, 1, 4);
    add(0, 0, 1, 1, 0, 1, 3);
    add(0, 0, 1, 1, 1, 1, 2);
    add(0, 0, 1, 1, 1, 1, 1);
    add(0, 0, 1, 0, 1, 1, 0);
    // Reset with credit=3 discards everything, clears drop, no stale pulses
    add(0, 1, 1, 0, 1, 1, 0);
    add(0, 1, 1, 1, 1, 1, 2);
    add(1, 1, 1, 0, 0, 1, 3);
    add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].a, tbl[i].br);
      if (tbl[i].b >= 0) check($sformatf("vec%0d_b", i), int'(bus.b), tbl[i].b);
      if (tbl[i].ar >= 0) check($sformatf("vec%0d_a_ready", i), int'(bus.a_ready), tbl[i].ar);
      if (tbl[i].credit >= 0) check($sformatf("vec%0d_credit", i), int'(dut.credit), tbl[i].credit);
`ifdef EXPAND_TOKENS_DROP_FLAG_EN
      if (tbl[i].drop >= 0) check($sformatf("vec%0d_drop", i), int'(bus.drop), tbl[i].drop);
`endif
    end

    // Steady full-rate traffic, then random traffic, both against the count model
    drive(1'b1, 1'b0, 1'b0);
    m_acc = 0; m_emit = 0; o_acc = 0; o_emit = 0;
    for (int i = 0; i < 24; i++) model_cycle(1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      model_cycle(logic'($urandom_range(0, 1)), logic'(($urandom % 4) != 0));
    end

    // FACTOR=3, CAP=3: single token drained under a toggling b_ready; extra offer while full is refused
    begin
      int a6[7]  = '{1, 0, 0, 1, 0, 0, 0};
      int br6[7] = '{0, 1, 0, 1, 0, 1, 1};
      int b6[7]  = '{0, 1, 0, 1, 0, 1, 0};
      int ar6[7] = '{1, 0, 0, 0, 0, 0, 1};
      drive3(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
        drive3(1'b0, logic'(a6[i]), logic'(br6[i]));
        check($sformatf("f3_b%0d", i), int'(bus3.b), b6[i]);
        check($sformatf("f3_a_ready%0d", i), int'(bus3.a_ready), ar6[i]);
      end
      drive3(1'b0, 1'b0, 1'b1);
      check("f3_final_b", int'(bus3.b), 0);
      check("f3_final_credit", int'(dut3.credit), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
